sweep_acq_engine: RTL and testbench
===================================

Name: sweep_acq_engine

Overview:
- Parametrised successor of the single-DAC sweep acquisition top.
- Steps one selected threshold DAC (of N_DAC) from a start code to an end code with programmable step and direction.
- At each point: reloads slow control, launches one acquisition, buffers a fixed number of data words, then streams a header word plus the buffered words on a valid/ready output.
- Sits between the USB/command layer, the Microroc SC loader and the readout data path.

Parameters:
- DAC_W, 10, DAC code width.
- N_DAC, 3, number of sweepable DACs; sel width SEL_W = clog2(N_DAC), minimum 1.
- DATA_W, 16, data/output word width; must be greater than DAC_W.
- FIFO_DEPTH, 128, internal buffer depth in words; power of 2.
- HDR_TAG, 6'b110000, upper (DATA_W-DAC_W) bits of the header word.

Ports:
- Clk  in  1  system clock.
- reset_n  in  1  async active-low reset.
- sweep_start  in  1  level; rising edge starts a sweep.
- sweep_abort  in  1  synchronous abort, level.
- start_dac  in  DAC_W  first code.
- end_dac  in  DAC_W  limit code; start > end gives a descending sweep.
- step_dac  in  DAC_W  step size; 0 is treated as 1.
- dac_sel  in  SEL_W  DAC to sweep.
- max_pkg  in  16  words to collect per point.
- out_dac  out  DAC_W  current code.
- out_dac_sel  out  SEL_W  latched dac_sel.
- load_sc  out  1  1-cycle SC reload pulse.
- sc_done  in  1  SC configuration complete.
- single_acq_start  out  1  1-cycle acquisition launch pulse.
- par_data  in  DATA_W  acquired word.
- par_data_en  in  1  par_data valid.
- dout  out  DATA_W  output word.
- dout_valid  out  1  dout valid.
- dout_ready  in  1  sink ready.
- single_dac_done  out  1  1-cycle pulse when a point completes.
- acq_done  out  1  1-cycle pulse when the sweep completes.
- busy  out  1  high whenever not IDLE.
- overflow  out  1  sticky: a word was dropped in the current sweep.

Behaviour:
- Reset values: every output 0; out_dac 0; out_dac_sel 0; FIFO empty.
- Start: sweep_start passes through a 2-flop edge detector. Edges are ignored unless IDLE.
- Start latches: start_dac, end_dac, step (0 becomes 1), dac_sel, max_pkg. Start also clears overflow and sets dir = (start_dac > end_dac).
- IDLE -> LOAD on start edge. out_dac = start_dac.
- LOAD: load_sc high for 1 cycle -> WAIT_CFG.
- WAIT_CFG: hold until sc_done = 1 -> ACQ_START. sc_done already high on entry is accepted on the next cycle.
- ACQ_START: single_acq_start high for 1 cycle; word counter cleared. -> ACQ, or -> HEADER when max_pkg = 0.
- ACQ: each par_data_en increments the counter.
  - The word is written if the FIFO is not full; otherwise it is dropped and overflow is set.
  - Counter reaches max_pkg -> HEADER. par_data_en in any other state is ignored.
- HEADER: dout = {HDR_TAG, out_dac}, dout_valid = 1. Transfers on valid & ready -> DRAIN.
- DRAIN: dout is driven from the FIFO head (first-word fall-through). Each valid & ready handshake pops one word. FIFO empty -> STEP.
- Output stream rule: dout and dout_valid are stable while valid & ~ready; no bubbles are required between words.
- STEP: single_dac_done high for 1 cycle.
  - Next code = out_dac ± step, computed in DAC_W+1 bits.
  - Ascending: the next code is used only if it is ≤ end_dac and did not carry; otherwise -> DONE.
  - Descending: the next code is used only if it is ≥ end_dac and did not borrow; otherwise -> DONE.
  - If the next code is used: out_dac updates -> LOAD.
  - The end code is visited only if it lies on the step grid. start = end gives exactly one point.
- DONE: acq_done high for 1 cycle -> IDLE. out_dac holds the last visited code.
- Abort: sweep_abort in any non-IDLE state -> IDLE next cycle.
  - FIFO flushed; dout_valid drops.
  - No single_dac_done or acq_done pulse.
  - out_dac holds its value.
  - Abort wins over any simultaneous transition.
- Simultaneous push and pop cannot occur: pushes happen only in ACQ, pops only in DRAIN.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits. Full and empty are derived from the pointer MSB compare.
- Async reset mid-sweep returns everything to the reset values above.

Test Plan:
- Ascending sweep: start=100, end=104, step=2, max_pkg=3, ready=1.
  - Required: 3 points (100, 102, 104) with 3 load_sc and 3 single_acq_start pulses.
  - Each point outputs header 0xC000|code, e.g. 0xC064 for 100, followed by the 3 data words in order.
  - Required: 3 single_dac_done pulses and 1 acq_done pulse.
- Descending, off-grid end: start=10, end=3, step=3.
  - Required: points 10, 7, 4 only.
  - Step 0 with start=5, end=6: required points 5, 6.
- Wrap guard: start=1020, end=1023, step=5. Required: a single point, 1020; the carry stops the sweep.
- Overflow: max_pkg=130, FIFO_DEPTH=128.
  - Required: 128 words output after the header; overflow=1 after the sweep.
  - overflow is cleared by the next start edge.
- Backpressure: toggle dout_ready randomly.
  - Required: dout stable while stalled; no word lost or duplicated.
  - max_pkg=0: header only, then the next point.
- Abort during WAIT_CFG, and separately during DRAIN.
  - Required: IDLE next cycle; no acq_done pulse; FIFO empty.
  - A new sweep_start edge then runs a normal sweep.

Source files
------------

// File: rtl/sweep_acq_engine_if.sv
// ---------------------------------------------------------------------------
// sweep_acq_engine_if
// Data-path bundle of the sweep acquisition engine.
//   par_data / par_data_en : acquired words from the readout path (into engine)
//   dout / dout_valid      : header + buffered words (out of engine)
//   dout_ready             : sink ready for the output stream
// master = engine side, slave = readout source / stream sink side.
// ---------------------------------------------------------------------------
interface sweep_acq_engine_if #(
   parameter int DATA_W = 16
);
   logic [DATA_W-1:0] par_data;
   logic              par_data_en;
   logic [DATA_W-1:0] dout;
   logic              dout_valid;
   logic              dout_ready;

   modport master (
      input  par_data, par_data_en, dout_ready,
      output dout, dout_valid
   );

   modport slave (
      output par_data, par_data_en, dout_ready,
      input  dout, dout_valid
   );
endinterface

// File: rtl/sweep_acq_engine.sv
// ---------------------------------------------------------------------------
// sweep_acq_engine
// Steps one selected threshold DAC from start_dac to end_dac. At each point:
// pulse load_sc, wait sc_done, pulse single_acq_start, buffer max_pkg words,
// then stream {HDR_TAG, code} followed by the buffered words.
// Ports:
//   Clk, reset_n          clock, async active-low reset
//   sweep_start           level, rising edge starts a sweep (IDLE only)
//   sweep_abort           level, returns to IDLE and flushes the buffer
//   start_dac/end_dac/step_dac/dac_sel/max_pkg   sweep setup, latched at start
//   out_dac, out_dac_sel  current code and latched DAC select
//   load_sc, sc_done      slow-control reload pulse / completion
//   single_acq_start      acquisition launch pulse
//   bus                   par_data in, dout valid/ready stream out
//   single_dac_done       point complete pulse
//   acq_done              sweep complete pulse
//   busy                  not IDLE
//   overflow              sticky: a word was dropped during this sweep
// ---------------------------------------------------------------------------
module sweep_acq_engine #(
   parameter int DAC_W      = 10,
   parameter int N_DAC      = 3,
   parameter int SEL_W      = (N_DAC > 1) ? $clog2(N_DAC) : 1,
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 128,
   parameter logic [DATA_W-DAC_W-1:0] HDR_TAG = 6'b110000
) (
   input  logic               Clk,
   input  logic               reset_n,
   input  logic               sweep_start,
   input  logic               sweep_abort,
   input  logic [DAC_W-1:0]   start_dac,
   input  logic [DAC_W-1:0]   end_dac,
   input  logic [DAC_W-1:0]   step_dac,
   input  logic [SEL_W-1:0]   dac_sel,
   input  logic [15:0]        max_pkg,
   output logic [DAC_W-1:0]   out_dac,
   output logic [SEL_W-1:0]   out_dac_sel,
   output logic               load_sc,
   input  logic               sc_done,
   output logic               single_acq_start,
   sweep_acq_engine_if.master bus,
   output logic               single_dac_done,
   output logic               acq_done,
   output logic               busy,
   output logic               overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_WAIT_CFG, S_ACQ_START, S_ACQ,
      S_HEADER, S_DRAIN, S_STEP, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic              start_s0_q, start_s1_q;
   logic              start_edge;
   logic [DAC_W-1:0]  dac_q, dac_d;
   logic [DAC_W-1:0]  end_q, step_q;
   logic              dir_q;               // 1 = descending
   logic [SEL_W-1:0]  sel_q;
   logic [15:0]       max_q;
   logic [15:0]       cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic [AW:0]       wr_q, wr_d, rd_q, rd_d;
   logic              push;
   logic              fifo_full, fifo_empty;
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [DAC_W:0]    nxt_up, nxt_dn;
   logic              step_ok;
   logic [DAC_W-1:0]  nxt_code;
   logic [DATA_W-1:0] dout_c;
   logic              dout_valid_c;

   assign start_edge = start_s0_q & ~start_s1_q;

   // Extra MSB on the pointers tells a full buffer from an empty one.
   assign fifo_empty = (wr_q == rd_q);
   assign fifo_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

   // One extra bit catches carry (ascending) or borrow (descending) past the code range.
   assign nxt_up   = {1'b0, dac_q} + {1'b0, step_q};
   assign nxt_dn   = {1'b0, dac_q} - {1'b0, step_q};
   assign nxt_code = dir_q ? nxt_dn[DAC_W-1:0] : nxt_up[DAC_W-1:0];
   assign step_ok  = dir_q ? (!nxt_dn[DAC_W] && (nxt_dn[DAC_W-1:0] >= end_q))
                           : (!nxt_up[DAC_W] && (nxt_up[DAC_W-1:0] <= end_q));

   always_comb begin
      state_d          = state_q;
      dac_d            = dac_q;
      cnt_d            = cnt_q;
      ovf_d            = ovf_q;
      wr_d             = wr_q;
      rd_d             = rd_q;
      push             = 1'b0;
      load_sc          = 1'b0;
      single_acq_start = 1'b0;
      single_dac_done  = 1'b0;
      acq_done         = 1'b0;
      dout_c           = '0;
      dout_valid_c     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_edge) begin
               state_d = S_LOAD;
               dac_d   = start_dac;
               ovf_d   = 1'b0;
            end
         end
         S_LOAD: begin
            load_sc = 1'b1;
            state_d = S_WAIT_CFG;
         end
         S_WAIT_CFG: begin
            if (sc_done) state_d = S_ACQ_START;
         end
         S_ACQ_START: begin
            single_acq_start = 1'b1;
            cnt_d            = '0;
            state_d          = (max_q == 16'd0) ? S_HEADER : S_ACQ;
         end
         S_ACQ: begin
            if (bus.par_data_en) begin
               cnt_d = cnt_q + 16'd1;
               if (!fifo_full) begin
                  push = 1'b1;
                  wr_d = wr_q + 1'b1;
               end else begin
                  ovf_d = 1'b1;
               end
               if (cnt_d == max_q) state_d = S_HEADER;
            end
         end
         S_HEADER: begin
            dout_c       = {HDR_TAG, dac_q};
            dout_valid_c = 1'b1;
            if (bus.dout_ready) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            // First-word fall-through: head word is visible without a pop.
            dout_c       = mem_q[rd_q[AW-1:0]];
            dout_valid_c = !fifo_empty;
            if (fifo_empty)          state_d = S_STEP;
            else if (bus.dout_ready) rd_d    = rd_q + 1'b1;
         end
         S_STEP: begin
            single_dac_done = 1'b1;
            if (step_ok) begin
               dac_d   = nxt_code;
               state_d = S_LOAD;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            acq_done = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Abort overrides whatever the state wanted this cycle.
      if (sweep_abort && (state_q != S_IDLE)) begin
         state_d          = S_IDLE;
         dac_d            = dac_q;
         ovf_d            = ovf_q;
         push             = 1'b0;
         wr_d             = '0;
         rd_d             = '0;
         load_sc          = 1'b0;
         single_acq_start = 1'b0;
         single_dac_done  = 1'b0;
         acq_done         = 1'b0;
      end
   end

   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         start_s0_q <= 1'b0;
         start_s1_q <= 1'b0;
         dac_q      <= '0;
         end_q      <= '0;
         step_q     <= '0;
         dir_q      <= 1'b0;
         sel_q      <= '0;
         max_q      <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         wr_q       <= '0;
         rd_q       <= '0;
      end else begin
         state_q    <= state_d;
         start_s0_q <= sweep_start;
         start_s1_q <= start_s0_q;
         dac_q      <= dac_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         if ((state_q == S_IDLE) && start_edge) begin
            end_q  <= end_dac;
            step_q <= (step_dac == '0) ? DAC_W'(1) : step_dac;
            dir_q  <= (start_dac > end_dac);
            sel_q  <= dac_sel;
            max_q  <= max_pkg;
         end
      end
   end

   // Storage needs no reset: pointers define what is valid.
   always_ff @(posedge Clk) begin
      if (push) mem_q[wr_q[AW-1:0]] <= bus.par_data;
   end

   assign out_dac        = dac_q;
   assign out_dac_sel    = sel_q;
   assign busy           = (state_q != S_IDLE);
   assign overflow       = ovf_q;
   assign bus.dout       = dout_c;
   assign bus.dout_valid = dout_valid_c;
endmodule

// File: tb/tb_sweep_acq_engine.sv
module tb_sweep_acq_engine;
   localparam int DAC_W      = 10;
   localparam int DATA_W     = 16;
   localparam int FIFO_DEPTH = 128;
   localparam int SEL_W      = 2;

   logic              Clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              sweep_start = 1'b0;
   logic              sweep_abort = 1'b0;
   logic [DAC_W-1:0]  start_dac = '0;
   logic [DAC_W-1:0]  end_dac = '0;
   logic [DAC_W-1:0]  step_dac = '0;
   logic [SEL_W-1:0]  dac_sel = '0;
   logic [15:0]       max_pkg = '0;
   logic [DAC_W-1:0]  out_dac;
   logic [SEL_W-1:0]  out_dac_sel;
   logic              load_sc, sc_done, single_acq_start;
   logic              single_dac_done, acq_done, busy, overflow;

   sweep_acq_engine_if #(.DATA_W(DATA_W)) bus ();

   sweep_acq_engine dut (
      .Clk(Clk), .reset_n(reset_n), .sweep_start(sweep_start), .sweep_abort(sweep_abort),
      .start_dac(start_dac), .end_dac(end_dac), .step_dac(step_dac), .dac_sel(dac_sel),
      .max_pkg(max_pkg), .out_dac(out_dac), .out_dac_sel(out_dac_sel), .load_sc(load_sc),
      .sc_done(sc_done), .single_acq_start(single_acq_start), .bus(bus),
      .single_dac_done(single_dac_done), .acq_done(acq_done), .busy(busy), .overflow(overflow)
   );

   always #5 Clk = ~Clk;

   int          n_cmp = 0, n_err = 0;
   int          pts[$];
   logic [15:0] exp_q[$], got_q[$];
   int          n_load, n_acq, n_ddone, n_adone;
   int          cur_max, acq_pt, rmode;
   bit          sc_low = 0, first_xfer = 0, prev_stall = 0, prev_abort = 0;
   logic [15:0] prev_dout;
   event        acq_ev;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      sc_done = 1'b0;
      bus.dout_ready = 1'b0;
      bus.par_data = '0;
      bus.par_data_en = 1'b0;
   end

   // Slow-control responder: random completion, or held low on demand.
   initial forever begin
      @(posedge Clk); #1;
      sc_done = sc_low ? 1'b0 : ($urandom_range(0, 2) == 0);
   end

   // Sink: 0 = always ready, 1 = random, 2 = take only the first word then stall.
   initial forever begin
      @(posedge Clk); #1;
      case (rmode)
         0:       bus.dout_ready = 1'b1;
         1:       bus.dout_ready = 1'($urandom_range(0, 1));
         default: bus.dout_ready = !first_xfer;
      endcase
   end

   // Data source: on each acquisition launch, queue the expected header, send
   // cur_max words with random gaps (only the first FIFO_DEPTH can be kept),
   // then one stray word that must be ignored.
   initial forever begin
      logic [9:0] code;
      @(acq_ev);
      code = (acq_pt < pts.size()) ? 10'(pts[acq_pt]) : 10'h3FF;
      exp_q.push_back({6'b110000, code});
      for (int i = 0; i < cur_max; i++) begin
         @(posedge Clk); #1;
         while ($urandom_range(0, 3) == 0) begin
            bus.par_data_en = 1'b0;
            @(posedge Clk); #1;
         end
         bus.par_data_en = 1'b1;
         bus.par_data    = 16'($urandom);
         if (i < FIFO_DEPTH) exp_q.push_back(bus.par_data);
      end
      @(posedge Clk); #1;
      bus.par_data_en = 1'b1;
      bus.par_data    = 16'hDEAD;
      @(posedge Clk); #1;
      bus.par_data_en = 1'b0;
   end

   // Monitor, sampled mid-cycle.
   initial forever begin
      @(negedge Clk);
      if (!reset_n) begin
         prev_stall = 0;
      end else begin
         if (load_sc) begin
            if (n_load < pts.size()) chk($sformatf("load_code%0d", n_load), 32'(out_dac), 32'(pts[n_load]));
            n_load++;
         end
         if (single_acq_start) begin
            acq_pt = n_acq;
            n_acq++;
            -> acq_ev;
         end
         if (single_dac_done) n_ddone++;
         if (acq_done)        n_adone++;
         if (prev_stall && !prev_abort) begin
            chk("stall_valid", 32'(bus.dout_valid), 32'd1);
            chk("stall_data", 32'(bus.dout), 32'(prev_dout));
         end
         if (bus.dout_valid && bus.dout_ready) begin
            got_q.push_back(bus.dout);
            first_xfer = 1;
         end
         prev_stall = bus.dout_valid && !bus.dout_ready;
         prev_dout  = bus.dout;
         prev_abort = sweep_abort;
      end
   end

   // Reference point list from the sweep rules, in plain integer arithmetic.
   task automatic setup(int s, int e, int st, int mp, int sel, int rm);
      int stp;
      stp = (st == 0) ? 1 : st;
      pts.delete();
      if (s <= e) for (int v = s; v <= e; v += stp) pts.push_back(v);
      else        for (int v = s; v >= e; v -= stp) pts.push_back(v);
      start_dac = 10'(s); end_dac = 10'(e); step_dac = 10'(st);
      dac_sel = 2'(sel); max_pkg = 16'(mp);
      exp_q.delete(); got_q.delete();
      n_load = 0; n_acq = 0; n_ddone = 0; n_adone = 0;
      cur_max = mp; rmode = rm; first_xfer = 0;
   endtask

   task automatic kick();
      @(posedge Clk); #1 sweep_start = 1'b1;
      repeat (2) @(posedge Clk);
      #1 sweep_start = 1'b0;
   endtask

   task automatic wait_done();
      for (int c = 0; c < 20000 && n_adone == 0; c++) @(posedge Clk);
      #1;
   endtask

   task automatic check_sweep(string nm, int sel);
      int n;
      @(negedge Clk);
      chk({nm, "_acq_done"}, 32'(n_adone), 32'd1);
      chk({nm, "_n_load"}, 32'(n_load), 32'(pts.size()));
      chk({nm, "_n_acq"}, 32'(n_acq), 32'(pts.size()));
      chk({nm, "_n_point_done"}, 32'(n_ddone), 32'(pts.size()));
      chk({nm, "_n_words"}, 32'(got_q.size()), 32'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk($sformatf("%s_word%0d", nm, i), 32'(got_q[i]), 32'(exp_q[i]));
      chk({nm, "_overflow"}, 32'(overflow), 32'(cur_max > FIFO_DEPTH));
      chk({nm, "_last_code"}, 32'(out_dac), 32'(pts[pts.size()-1]));
      chk({nm, "_sel"}, 32'(out_dac_sel), 32'(sel));
      chk({nm, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic run(string nm, int s, int e, int st, int mp, int sel, int rm);
      setup(s, e, st, mp, sel, rm);
      kick();
      wait_done();
      check_sweep(nm, sel);
   endtask

   initial begin
      int s, e, d, c;
      rmode = 0;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_dac", 32'(out_dac), 32'd0);
      chk("rst_sel", 32'(out_dac_sel), 32'd0);
      chk("rst_valid", 32'(bus.dout_valid), 32'd0);
      chk("rst_dout", 32'(bus.dout), 32'd0);
      chk("rst_pulses", 32'({load_sc, single_acq_start, single_dac_done, acq_done, overflow}), 32'd0);
      #2 reset_n = 1'b1;

      run("asc", 100, 104, 2, 3, 1, 0);
      chk("asc_hdr0", 32'(got_q.size() > 0 ? got_q[0] : 16'h0), 32'h0000C064);
      run("desc_offgrid", 10, 3, 3, 2, 2, 1);
      run("wrap_guard", 1020, 1023, 5, 1, 0, 1);
      run("overflow", 7, 7, 1, 130, 1, 0);
      run("step_zero", 5, 6, 0, 2, 0, 1);       // also shows overflow cleared
      run("bp_empty_pkg", 40, 46, 3, 0, 2, 1);

      for (int k = 0; k < 6; k++) begin
         s = $urandom_range(0, 1023);
         d = $urandom_range(0, 30);
         if ($urandom_range(0, 1)) e = (s + d > 1023) ? 1023 : s + d;
         else                      e = (s < d) ? 0 : s - d;
         run($sformatf("rand%0d", k), s, e, $urandom_range(0, 6), $urandom_range(0, 5),
             $urandom_range(0, 2), 1);
      end

      // Abort while waiting for slow control.
      setup(200, 210, 5, 2, 1, 0);
      sc_low = 1;
      kick();
      for (c = 0; c < 50 && n_load == 0; c++) @(posedge Clk);
      repeat (2) @(posedge Clk);
      #1 sweep_abort = 1'b1;
      @(posedge Clk); #1 sweep_abort = 1'b0;
      @(negedge Clk);
      chk("abort_cfg_busy", 32'(busy), 32'd0);
      chk("abort_cfg_valid", 32'(bus.dout_valid), 32'd0);
      chk("abort_cfg_code", 32'(out_dac), 32'd200);
      repeat (4) @(posedge Clk);
      chk("abort_cfg_no_done", 32'({n_adone[7:0], n_ddone[7:0]}), 32'd0);
      sc_low = 0;
      run("after_abort_cfg", 300, 306, 3, 2, 0, 1);

      // Abort with buffered words still pending in the output drain.
      setup(50, 60, 10, 4, 2, 2);
      kick();
      for (c = 0; c < 500 && !first_xfer; c++) @(posedge Clk);
      repeat (3) @(posedge Clk);
      #1 sweep_abort = 1'b1;
      @(posedge Clk); #1 sweep_abort = 1'b0;
      @(negedge Clk);
      chk("abort_drain_busy", 32'(busy), 32'd0);
      chk("abort_drain_valid", 32'(bus.dout_valid), 32'd0);
      chk("abort_drain_code", 32'(out_dac), 32'd50);
      repeat (4) @(posedge Clk);
      chk("abort_drain_no_done", 32'({n_adone[7:0], n_ddone[7:0]}), 32'd0);
      run("after_abort_drain", 600, 590, 5, 3, 1, 1);

      // Asynchronous reset in the middle of a sweep.
      setup(300, 320, 4, 3, 3, 1);
      kick();
      for (c = 0; c < 200 && n_acq == 0; c++) @(posedge Clk);
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_code", 32'(out_dac), 32'd0);
      chk("midrst_sel", 32'(out_dac_sel), 32'd0);
      chk("midrst_valid", 32'(bus.dout_valid), 32'd0);
      repeat (20) @(posedge Clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
